// File: rtl/ppu_spgen_bank.sv
// rtl/ppu_spgen_bank.sv - bank of scanline sprite slots with priority mux and collision flag
module ppu_spgen_bank #(
    parameter int NUM_SLOTS = 8,
    parameter int SCALE_W   = 2,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic               clk_25mhz,
    input  logic               rst,
    input  logic               enable,
    input  logic               line_start,
    input  logic               load,
    input  logic [SLOT_W-1:0]  load_slot,
    input  logic [7:0]         xpos,
    input  logic [7:0]         attr,
    input  logic [7:0]         line0,
    input  logic [7:0]         line1,
    input  logic [SCALE_W-1:0] scalex,
    output logic [3:0]         pixel_out,
    output logic               pixel_valid,
    output logic               pixel_behind,
    output logic [SLOT_W-1:0]  win_slot,
    output logic               collision
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAW,
        S_DONE
    } slot_state_t;

    slot_state_t        state       [NUM_SLOTS];
    logic [7:0]         down_count  [NUM_SLOTS];
    logic [SCALE_W-1:0] scale_count [NUM_SLOTS];
    logic [2:0]         pix_idx     [NUM_SLOTS];
    logic [7:0]         shift0      [NUM_SLOTS];
    logic [7:0]         shift1      [NUM_SLOTS];
    // Only behind-background and palette matter after load; fliph is applied at load time.
    logic [2:0]         attr_q      [NUM_SLOTS];

    logic [1:0]         color       [NUM_SLOTS];
    logic               win_found;
    logic               multi_opaque;
    logic [SLOT_W-1:0]  win_idx;
    logic [1:0]         win_color;
    logic [2:0]         win_attr;

    wire unused_attr_bits = &{1'b0, attr[7], attr[4:2]};

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b] = v[7-b];
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            color[i] = (state[i] == S_DRAW) ? {shift1[i][7], shift0[i][7]} : 2'b00;
        end
    end

    // Lowest opaque slot wins; any further opaque slot marks a collision.
    always_comb begin
        win_found    = 1'b0;
        multi_opaque = 1'b0;
        win_idx      = '0;
        win_color    = 2'b00;
        win_attr     = 3'b000;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (color[i] != 2'b00) begin
                if (win_found) begin
                    multi_opaque = 1'b1;
                end else begin
                    win_found = 1'b1;
                    win_idx   = SLOT_W'(i);
                    win_color = color[i];
                    win_attr  = attr_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state[i]       <= S_IDLE;
                down_count[i]  <= 8'h00;
                scale_count[i] <= '0;
                pix_idx[i]     <= 3'd0;
                shift0[i]      <= 8'h00;
                shift1[i]      <= 8'h00;
                attr_q[i]      <= 3'b000;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (load && (load_slot == SLOT_W'(i))) begin
                    scale_count[i] <= scalex;
                    down_count[i]  <= xpos;
                    pix_idx[i]     <= 3'd0;
                    attr_q[i]      <= {attr[5], attr[1:0]};
                    shift0[i]      <= attr[6] ? rev8(line0) : line0;
                    shift1[i]      <= attr[6] ? rev8(line1) : line1;
                    if (xpos == 8'hFF) begin
                        state[i] <= S_IDLE;
                    end else if (xpos == 8'h00) begin
                        state[i] <= S_DRAW;
                    end else begin
                        state[i] <= S_WAIT;
                    end
                end else if (line_start) begin
                    state[i] <= S_IDLE;
                end else if (!enable) begin
                    scale_count[i] <= scalex;
                end else if (scale_count[i] != '0) begin
                    scale_count[i] <= scale_count[i] - 1'b1;
                end else begin
                    scale_count[i] <= scalex;
                    case (state[i])
                        S_WAIT: begin
                            down_count[i] <= down_count[i] - 8'd1;
                            if (down_count[i] == 8'd1) begin
                                state[i]   <= S_DRAW;
                                pix_idx[i] <= 3'd0;
                            end
                        end
                        S_DRAW: begin
                            shift0[i]  <= {shift0[i][6:0], 1'b0};
                            shift1[i]  <= {shift1[i][6:0], 1'b0};
                            pix_idx[i] <= pix_idx[i] + 3'd1;
                            if (pix_idx[i] == 3'd7) begin
                                state[i] <= S_DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            pixel_out    <= 4'h0;
            pixel_valid  <= 1'b0;
            pixel_behind <= 1'b0;
            win_slot     <= '0;
            collision    <= 1'b0;
        end else begin
            if (line_start) begin
                collision <= 1'b0;
            end else if (enable && multi_opaque) begin
                collision <= 1'b1;
            end
            if (enable) begin
                pixel_out    <= win_found ? {win_attr[1:0], win_color} : 4'h0;
                pixel_valid  <= win_found;
                pixel_behind <= win_found & win_attr[2];
                win_slot     <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_ppu_spgen_bank.sv
// tb/tb_ppu_spgen_bank.sv - directed self-checking bench for ppu_spgen_bank
module tb_ppu_spgen_bank;

    logic       clk_25mhz = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       line_start = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_slot = 3'd0;
    logic [7:0] xpos = 8'h00;
    logic [7:0] attr = 8'h00;
    logic [7:0] line0 = 8'h00;
    logic [7:0] line1 = 8'h00;
    logic [1:0] scalex = 2'd0;
    logic [3:0] pixel_out;
    logic       pixel_valid;
    logic       pixel_behind;
    logic [2:0] win_slot;
    logic       collision;

    int checks = 0;
    int failures = 0;
    int expq[$];

    always #20 clk_25mhz = ~clk_25mhz;

    ppu_spgen_bank dut (
        .clk_25mhz    (clk_25mhz),
        .rst          (rst),
        .enable       (enable),
        .line_start   (line_start),
        .load         (load),
        .load_slot    (load_slot),
        .xpos         (xpos),
        .attr         (attr),
        .line0        (line0),
        .line1        (line1),
        .scalex       (scalex),
        .pixel_out    (pixel_out),
        .pixel_valid  (pixel_valid),
        .pixel_behind (pixel_behind),
        .win_slot     (win_slot),
        .collision    (collision)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_25mhz);
    endtask

    task automatic new_line();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic load_one(input int s, input logic [7:0] xp, input logic [7:0] at,
                            input logic [7:0] l0, input logic [7:0] l1, input logic [1:0] sc);
        load      = 1'b1;
        load_slot = 3'(s);
        xpos      = xp;
        attr      = at;
        line0     = l0;
        line1     = l1;
        scalex    = sc;
        tick();
        load = 1'b0;
    endtask

    task automatic run_expect(input string tag);
        for (int k = 0; k < expq.size(); k++) begin
            enable = 1'b1;
            tick();
            check($sformatf("%s_pix%0d", tag, k), pixel_out, expq[k]);
            check($sformatf("%s_val%0d", tag, k), pixel_valid, expq[k] != 0);
        end
        enable = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_pixel", pixel_out, 4'h0);
        check("rst_valid", pixel_valid, 1'b0);
        check("rst_win", win_slot, 3'd0);
        check("rst_coll", collision, 1'b0);
        rst = 1'b0;
        tick();

        new_line();
        load_one(0, 8'd3, 8'h01, 8'h0F, 8'hAA, 2'd0);
        expq = '{0, 0, 0, 6, 0, 6, 0, 7, 5, 7, 5, 0};
        run_expect("basic");

        new_line();
        load_one(0, 8'd3, 8'h41, 8'h0F, 8'hAA, 2'd0);
        expq = '{0, 0, 0, 5, 7, 5, 7, 0, 6, 0, 6, 0};
        run_expect("fliph");

        new_line();
        load_one(0, 8'd3, 8'h01, 8'h0F, 8'hAA, 2'd1);
        expq = '{0, 0, 0, 0, 0, 0, 6, 6, 0, 0, 6, 6, 0, 0, 7, 7, 5, 5, 7, 7, 5, 5, 0, 0};
        run_expect("scale");

        // Stalled enable mid-sprite: outputs hold, then resume unbroken.
        new_line();
        load_one(0, 8'd0, 8'h01, 8'h0F, 8'hAA, 2'd0);
        expq = '{6, 0, 6};
        run_expect("stall_a");
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("stall_hold%0d", k), pixel_out, 4'h6);
        end
        expq = '{0, 7, 5, 7, 5, 0};
        run_expect("stall_b");

        // Load coincident with line_start survives for its slot.
        load      = 1'b1;
        line_start = 1'b1;
        load_slot = 3'd2;
        xpos      = 8'd0;
        attr      = 8'h22;
        line0     = 8'hFF;
        line1     = 8'h00;
        scalex    = 2'd0;
        tick();
        line_start = 1'b0;
        load = 1'b0;
        load_one(5, 8'd0, 8'h03, 8'hFF, 8'h00, 2'd0);
        check("coll_pre", collision, 1'b0);
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("coll_pix%0d", k), pixel_out, 4'h9);
            check($sformatf("coll_win%0d", k), win_slot, 3'd2);
            check($sformatf("coll_behind%0d", k), pixel_behind, 1'b1);
            check($sformatf("coll_flag%0d", k), collision, 1'b1);
        end
        tick();
        check("coll_end_pix", pixel_out, 4'h0);
        check("coll_end_win", win_slot, 3'd0);
        check("coll_end_behind", pixel_behind, 1'b0);
        check("coll_sticky", collision, 1'b1);
        enable = 1'b0;
        tick();
        check("coll_hold", collision, 1'b1);
        new_line();
        check("coll_clear", collision, 1'b0);

        // Unused-slot load kills an active sprite.
        load_one(0, 8'd0, 8'h01, 8'h0F, 8'hAA, 2'd0);
        expq = '{6, 0};
        run_expect("ff_a");
        load_one(0, 8'hFF, 8'h01, 8'h0F, 8'hAA, 2'd0);
        expq = '{0, 0};
        run_expect("ff_b");

        // Reset in the middle of drawing.
        new_line();
        load_one(0, 8'd0, 8'h01, 8'h0F, 8'hAA, 2'd0);
        expq = '{6};
        run_expect("rst_a");
        enable = 1'b1;
        rst = 1'b1;
        tick();
        check("rstmid_pix", pixel_out, 4'h0);
        check("rstmid_val", pixel_valid, 1'b0);
        rst = 1'b0;
        enable = 1'b0;
        expq = '{0, 0, 0};
        run_expect("rst_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
